// File: rtl/bloco_pipe.sv
// bloco_pipe: two-stage register-file / ALU / ZCSO-flags datapath.
// Stage 0 reads operands (with forwarding from the committing instruction),
// stage 1 holds one instruction, executes it combinationally and commits
// writeback plus flags on the output handshake.
module bloco_pipe #(
    parameter int bits_palavra = 16,
    parameter int n_registros = 16,
    localparam int end_registros = $clog2(n_registros)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               op,
    input  logic [end_registros-1:0] sel_d,
    input  logic [end_registros-1:0] sel_a,
    input  logic [end_registros-1:0] sel_b,
    input  logic [bits_palavra-1:0]  imm,
    input  logic                     flags_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [bits_palavra-1:0]  result,
    output logic [3:0]               flags_zcso
);

    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_SUB = 5'h01;
    localparam logic [4:0] OP_ADC = 5'h02;
    localparam logic [4:0] OP_AND = 5'h03;
    localparam logic [4:0] OP_OR  = 5'h04;
    localparam logic [4:0] OP_XOR = 5'h05;
    localparam logic [4:0] OP_NOT = 5'h06;
    localparam logic [4:0] OP_SHL = 5'h07;
    localparam logic [4:0] OP_SHR = 5'h08;
    localparam logic [4:0] OP_LDI = 5'h09;
    localparam logic [4:0] OP_CMP = 5'h0A;

    localparam int MSB = bits_palavra - 1;

    logic [bits_palavra-1:0]  rf [n_registros];
    logic [3:0]               flags_q;

    logic                     s1_valid;
    logic [4:0]               s1_op;
    logic [end_registros-1:0] s1_d;
    logic [bits_palavra-1:0]  s1_a;
    logic [bits_palavra-1:0]  s1_b;
    logic [bits_palavra-1:0]  s1_imm;

    logic [bits_palavra-1:0]  alu_res;
    logic [3:0]               alu_flags;
    logic                     alu_writes;
    logic [bits_palavra:0]    sum;
    logic                     carry_in;

    logic                     accept;
    logic                     commit;
    logic                     wr_en;
    logic [bits_palavra-1:0]  opnd_a;
    logic [bits_palavra-1:0]  opnd_b;

    assign in_ready   = !s1_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign commit     = s1_valid && out_ready;
    assign wr_en      = commit && alu_writes && (s1_d != '0);
    assign out_valid  = s1_valid;
    assign result     = alu_res;
    assign flags_zcso = flags_q;

    // R0 is never written, so its read is always zero; forwarding only
    // triggers on a real (non-R0) writeback happening this cycle.
    assign opnd_a = (wr_en && (s1_d == sel_a)) ? alu_res : rf[sel_a];
    assign opnd_b = (wr_en && (s1_d == sel_b)) ? alu_res : rf[sel_b];

    // ALU and next-flag computation from the stage-1 operands
    always_comb begin
        alu_res    = '0;
        alu_flags  = flags_q;
        alu_writes = 1'b1;
        sum        = '0;
        carry_in   = (s1_op == OP_ADC) ? flags_q[2] : 1'b0;
        unique case (s1_op)
            OP_ADD, OP_ADC: begin
                sum          = {1'b0, s1_a} + {1'b0, s1_b} + {{bits_palavra{1'b0}}, carry_in};
                alu_res      = sum[MSB:0];
                alu_flags[2] = sum[bits_palavra];
                alu_flags[0] = (s1_a[MSB] == s1_b[MSB]) && (alu_res[MSB] != s1_a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                // the extra top bit of the widened difference is the borrow
                sum          = {1'b0, s1_a} - {1'b0, s1_b};
                alu_res      = sum[MSB:0];
                alu_flags[2] = sum[bits_palavra];
                alu_flags[0] = (s1_a[MSB] != s1_b[MSB]) && (alu_res[MSB] != s1_a[MSB]);
                alu_writes   = (s1_op == OP_SUB);
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                case (s1_op)
                    OP_AND:  alu_res = s1_a & s1_b;
                    OP_OR:   alu_res = s1_a | s1_b;
                    OP_XOR:  alu_res = s1_a ^ s1_b;
                    default: alu_res = ~s1_a;
                endcase
                alu_flags[2] = 1'b0;
                alu_flags[0] = 1'b0;
            end
            OP_SHL: begin
                alu_res      = {s1_a[MSB-1:0], 1'b0};
                alu_flags[2] = s1_a[MSB];
                alu_flags[0] = 1'b0;
            end
            OP_SHR: begin
                alu_res      = {1'b0, s1_a[MSB:1]};
                alu_flags[2] = s1_a[0];
                alu_flags[0] = 1'b0;
            end
            OP_LDI: begin
                alu_res = s1_imm;
            end
            default: begin
                alu_res    = '0;
                alu_writes = 1'b0;
            end
        endcase
        if (s1_op <= OP_CMP) begin
            alu_flags[3] = (alu_res == '0);
            alu_flags[1] = alu_res[MSB];
        end
    end

    // Stage-1 holding register: load on accept, empty on commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_d     <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_imm   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= op;
            s1_d     <= sel_d;
            s1_a     <= opnd_a;
            s1_b     <= opnd_b;
            s1_imm   <= imm;
        end else if (commit) begin
            s1_valid <= 1'b0;
        end
    end

    // Register file writeback on commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < n_registros; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[s1_d] <= alu_res;
        end
    end

    // Flag register: clear wins over a concurrent commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= '0;
        end else if (flags_clr) begin
            flags_q <= '0;
        end else if (commit) begin
            flags_q <= alu_flags;
        end
    end

endmodule
